// File: rtl/axi_axis_reader.sv
// AXI4-Lite slave exposing an AXI-Stream input FIFO: DATA pops the head, STATUS reports the
// fill level, CTRL[0] flushes. The head word is read combinationally (first-word-fall-through).
module axi_axis_reader #(
  parameter int unsigned AXI_DATA_WIDTH  = 32,
  parameter int unsigned AXI_ADDR_WIDTH  = 16,
  parameter int unsigned FIFO_ADDR_WIDTH = 10
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready
);

  localparam int unsigned Depth = 2 ** FIFO_ADDR_WIDTH;
  localparam int unsigned CntW  = FIFO_ADDR_WIDTH + 1;

  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;

  // FIFO storage and bookkeeping
  logic [AXI_DATA_WIDTH-1:0]  mem_q [Depth];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]            count_q, count_d;
  logic                       full, empty, push, pop;

  // Write channel
  logic       aw_held_q, aw_held_d;
  logic       w_held_q, w_held_d;
  logic [1:0] awsel_q, awsel_d;
  logic       wbit_q, wbit_d;
  logic       bvalid_q, bvalid_d;
  logic       aw_hs, w_hs, wr_exec, flush_now;
  logic [1:0] wr_sel;
  logic       wr_bit;

  // Read channel
  logic                      rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [AXI_DATA_WIDTH-1:0] status, rd_mux;
  logic [1:0]                rd_sel;
  logic                      ar_hs;

  logic unused_bits;
  assign unused_bits = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:4], s_axi_awaddr[1:0],
                         s_axi_araddr[AXI_ADDR_WIDTH-1:4], s_axi_araddr[1:0],
                         s_axi_wdata[AXI_DATA_WIDTH-1:1]};

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);

  assign s_axi_awready = ~aw_held_q & ~bvalid_q & ~areset;
  assign s_axi_wready  = ~w_held_q & ~bvalid_q & ~areset;
  assign s_axi_arready = ~rvalid_q & ~areset;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // A half arriving this cycle counts as held so bvalid follows the later handshake by one cycle.
  assign wr_sel    = aw_held_q ? awsel_q : s_axi_awaddr[3:2];
  assign wr_bit    = w_held_q ? wbit_q : s_axi_wdata[0];
  assign wr_exec   = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign flush_now = wr_exec & (wr_sel == RegCtrl) & wr_bit;

  assign s_axis_tready = ~full & ~flush_now & ~areset;
  assign push          = s_axis_tvalid & s_axis_tready;

  assign rd_sel = s_axi_araddr[3:2];
  assign pop    = ar_hs & (rd_sel == RegData) & ~empty;

  always_comb begin
    status        = '0;
    status[15:0]  = 16'(count_q);
    status[16]    = full;
    status[17]    = empty;
  end

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      RegData:   if (!empty) rd_mux = mem_q[rd_ptr_q];
      RegStatus: rd_mux = status;
      default:   rd_mux = '0;
    endcase
  end

  // Flush takes priority over any same-cycle pop; the pop's read data is still captured.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_now) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + FIFO_ADDR_WIDTH'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awsel_d   = awsel_q;
    wbit_d    = wbit_q;
    bvalid_d  = bvalid_q;
    if (aw_hs) awsel_d = s_axi_awaddr[3:2];
    if (w_hs)  wbit_d  = s_axi_wdata[0];
    if (wr_exec) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
    end else begin
      if (aw_hs) aw_held_d = 1'b1;
      if (w_hs)  w_held_d  = 1'b1;
      if (s_axi_bready) bvalid_d = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awsel_q   <= '0;
      wbit_q    <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awsel_q   <= awsel_d;
      wbit_q    <= wbit_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule
